// File: rtl/burst_arb_ctrl.sv
// Round-robin burst arbiter: grants one requester at a time for a len+1 beat
// burst. A grant ends on the last beat, when the owner drops its request, or on a stall timeout.
module burst_arb_ctrl #(
    parameter int NUM_REQ = 6,
    parameter int LEN_W   = 4,
    parameter int TO_CYC  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] len,
    input  logic                     res_ready,
    output logic [NUM_REQ-1:0]       grant,
    output logic [2:0]               gnt_id,
    output logic                     busy,
    output logic                     beat_en,
    output logic                     last_beat,
    output logic                     timeout_err
);

    localparam int ST_W = $clog2(TO_CYC + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state, state_nx;
    logic [2:0]              ptr, win_id, gnt_id_nx;
    logic                    win_vld, owner_req, owner_drop, stalled, timeout_hit, to_err_nx;
    logic [NUM_REQ-1:0]      grant_nx;
    logic [LEN_W-1:0]        beat_cnt;
    logic [ST_W-1:0]         stall_cnt;
    logic [7:0]              req_pad;
    logic [7:0][LEN_W-1:0]   len_pad;

    // Pad to the full 3-bit index space so gnt_id/win_id can index directly.
    assign req_pad = 8'(req);
    assign len_pad = (8*LEN_W)'(len);

    assign busy        = (state == GRANT);
    assign owner_req   = req_pad[gnt_id];
    assign owner_drop  = busy & ~owner_req;
    assign beat_en     = busy & res_ready & owner_req;
    assign last_beat   = beat_en & (beat_cnt == '0);
    assign stalled     = busy & ~res_ready;
    assign timeout_hit = stalled & (stall_cnt == ST_W'(TO_CYC - 1));

    // Round-robin search starting one past the last winner.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!win_vld && req_pad[idx[2:0]]) begin
                win_vld = 1'b1;
                win_id  = idx[2:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win_vld) state_nx = GRANT;
            GRANT:   if (owner_drop || last_beat || timeout_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A req drop takes priority over a coincident timeout: no error pulse then.
    always_comb begin
        grant_nx  = grant;
        gnt_id_nx = gnt_id;
        to_err_nx = 1'b0;
        if (state == IDLE && win_vld) begin
            grant_nx  = NUM_REQ'(1) << win_id;
            gnt_id_nx = win_id;
        end else if (state == GRANT && state_nx == IDLE) begin
            grant_nx  = '0;
            gnt_id_nx = '0;
            to_err_nx = owner_req & timeout_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant       <= '0;
            gnt_id      <= '0;
            timeout_err <= 1'b0;
            ptr         <= 3'(NUM_REQ - 1);
            beat_cnt    <= '0;
            stall_cnt   <= '0;
        end else begin
            grant       <= grant_nx;
            gnt_id      <= gnt_id_nx;
            timeout_err <= to_err_nx;
            if (state == IDLE && win_vld) begin
                ptr      <= win_id;
                beat_cnt <= len_pad[win_id];
            end else if (beat_en && !last_beat) begin
                beat_cnt <= beat_cnt - 1'b1;
            end
            stall_cnt <= (stalled && state_nx == GRANT) ? stall_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_burst_arb_ctrl.sv
// Bench for burst_arb_ctrl: expected grant order goes into a queue as each
// scenario is driven; the monitor pops it on every new grant.
module tb_burst_arb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  req;
    logic [23:0] len;
    logic        res_ready;
    logic [5:0]  grant;
    logic [2:0]  gnt_id;
    logic        busy, beat_en, last_beat, timeout_err;

    int vecs = 0;
    int errs = 0;
    int exp_q[$];
    logic prev_busy = 1'b0;

    burst_arb_ctrl #(.NUM_REQ(6), .LEN_W(4), .TO_CYC(16)) dut (
        .clk(clk), .rst(rst), .req(req), .len(len), .res_ready(res_ready),
        .grant(grant), .gnt_id(gnt_id), .busy(busy), .beat_en(beat_en),
        .last_beat(last_beat), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Grant-order scoreboard plus one-hot/idle invariants every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && !prev_busy) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL grant_order: got gnt_id=%0d, expected no grant", gnt_id);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (gnt_id !== 3'(e) || grant !== (6'b000001 << e)) begin
                        errs++;
                        $display("FAIL grant_order: got gnt_id=%0d grant=%b, expected id %0d", gnt_id, grant, e);
                    end
                end
            end
            vecs++;
            if (busy ? (gnt_id > 3'd5 || grant !== (6'b000001 << gnt_id)) : (grant !== 6'b0 || gnt_id !== 3'd0)) begin
                errs++;
                $display("FAIL grant_shape: busy=%b grant=%b gnt_id=%0d", busy, grant, gnt_id);
            end
        end
        prev_busy = rst ? 1'b0 : busy;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; len = '0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 6'b111111; len = '1; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        vecs++;
        if (grant !== 6'b0 || gnt_id !== 3'd0 || busy !== 1'b0 || timeout_err !== 1'b0 || beat_en !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: grant=%b gnt_id=%0d busy=%b to=%b beat_en=%b, expected all zero",
                     grant, gnt_id, busy, timeout_err, beat_en);
        end
    endtask

    task automatic test_two_req();
        logic [5:0] exp_g [4];
        exp_g = '{6'b000000, 6'b000001, 6'b000000, 6'b100000};
        do_reset();
        req = 6'b100001;
        exp_q.push_back(0);
        exp_q.push_back(5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vecs++;
            if (grant !== exp_g[i] || last_beat !== (exp_g[i] != 6'b0)) begin
                errs++;
                $display("FAIL two_req c%0d: grant=%b last=%b, expected grant=%b", i, grant, last_beat, exp_g[i]);
            end
            next_cycle();
        end
        req = '0;
        repeat (2) next_cycle();
    endtask

    task automatic test_rotate();
        logic [5:0] eg;
        do_reset();
        req = 6'b111111;
        for (int k = 0; k < 7; k++) exp_q.push_back(k % 6);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            eg = (i % 2 == 1) ? (6'b000001 << ((i / 2) % 6)) : 6'b0;
            vecs++;
            if (grant !== eg) begin
                errs++;
                $display("FAIL rotate c%0d: grant=%b, expected %b", i, grant, eg);
            end
            next_cycle();
        end
        req = '0;
        repeat (2) next_cycle();
    endtask

    task automatic test_burst_stall();
        int nb = 0, nl = 0, nbusy = 0, last_at = -1;
        do_reset();
        req = 6'b000100;
        len[8 +: 4] = 4'd3;
        exp_q.push_back(2);
        for (int i = 0; i < 9; i++) begin
            if (i == 1) len[8 +: 4] = 4'd0;
            @(negedge clk);
            if (beat_en) nb++;
            if (last_beat) begin nl++; last_at = nb; end
            if (busy) nbusy++;
            next_cycle();
            res_ready = ~res_ready;
        end
        req = '0;
        res_ready = 1'b1;
        @(negedge clk);
        vecs++;
        if (nb != 4 || nl != 1 || last_at != 4) begin
            errs++;
            $display("FAIL burst_beats: beats=%0d lasts=%0d last_at=%0d, expected 4/1/4", nb, nl, last_at);
        end
        vecs++;
        if (nbusy != 8 || busy !== 1'b0) begin
            errs++;
            $display("FAIL burst_busy: busy_cycles=%0d busy_now=%b, expected 8/0", nbusy, busy);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        int nbusy = 0, nto = 0, nbeat = 0;
        do_reset();
        req = 6'b000010;
        len[4 +: 4] = 4'd5;
        res_ready = 1'b0;
        exp_q.push_back(1);
        exp_q.push_back(2);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (timeout_err) nto++;
            if (beat_en) nbeat++;
            next_cycle();
        end
        req = 6'b000111;
        @(negedge clk);
        vecs++;
        if (nbusy != 16 || nto != 0 || nbeat != 0) begin
            errs++;
            $display("FAIL timeout_stall: busy=%0d early_to=%0d beats=%0d, expected 16/0/0", nbusy, nto, nbeat);
        end
        vecs++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || grant !== 6'b0) begin
            errs++;
            $display("FAIL timeout_pulse: to=%b busy=%b grant=%b, expected 1/0/0", timeout_err, busy, grant);
        end
        next_cycle();
        @(negedge clk);
        vecs++;
        if (timeout_err !== 1'b0 || gnt_id !== 3'd2) begin
            errs++;
            $display("FAIL timeout_next: to=%b gnt_id=%0d, expected 0/2", timeout_err, gnt_id);
        end
        next_cycle();
        req = '0;
        res_ready = 1'b1;
        repeat (2) next_cycle();
    endtask

    task automatic test_drop();
        int nto = 0;
        do_reset();
        req = 6'b010000;
        len[16 +: 4] = 4'd7;
        exp_q.push_back(4);
        exp_q.push_back(5);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vecs++;
            if (beat_en !== 1'b1) begin
                errs++;
                $display("FAIL drop_beat%0d: beat_en=%b, expected 1", i, beat_en);
            end
            next_cycle();
        end
        req = '0;
        @(negedge clk);
        vecs++;
        if (busy !== 1'b1 || beat_en !== 1'b0 || gnt_id !== 3'd4) begin
            errs++;
            $display("FAIL drop_cycle: busy=%b beat_en=%b gnt_id=%0d, expected 1/0/4", busy, beat_en, gnt_id);
        end
        next_cycle();
        req = 6'b101001;
        @(negedge clk);
        if (timeout_err) nto++;
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL drop_idle: busy=%b, expected 0", busy);
        end
        next_cycle();
        @(negedge clk);
        if (timeout_err) nto++;
        next_cycle();
        req = '0;
        @(negedge clk);
        if (timeout_err) nto++;
        vecs++;
        if (nto != 0) begin
            errs++;
            $display("FAIL drop_no_timeout: pulses=%0d, expected 0", nto);
        end
        next_cycle();
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 6'b001000;
        len[12 +: 4] = 4'd7;
        exp_q.push_back(3);
        exp_q.push_back(0);
        next_cycle();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        vecs++;
        if (grant !== 6'b0 || busy !== 1'b0 || timeout_err !== 1'b0 || gnt_id !== 3'd0) begin
            errs++;
            $display("FAIL async_reset: grant=%b busy=%b to=%b gnt_id=%0d, expected all zero",
                     grant, busy, timeout_err, gnt_id);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        req = 6'b001001;
        next_cycle();
        @(negedge clk);
        vecs++;
        if (grant !== 6'b000001 || gnt_id !== 3'd0) begin
            errs++;
            $display("FAIL reset_restart: grant=%b gnt_id=%0d, expected 000001/0", grant, gnt_id);
        end
        next_cycle();
        req = '0;
        repeat (2) next_cycle();
    endtask

    initial begin
        test_reset();
        test_two_req();
        test_rotate();
        test_burst_stall();
        test_timeout();
        test_drop();
        test_mid_reset();
        vecs++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL pending_grants: %0d expected grants never seen, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/burst_arb_ctrl.md
BURST_ARB_CTRL -- requirements
Module: burst_arb_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 6: number of requesters, legal range 2..8.
REQ-002 The module SHALL have parameter LEN_W, default 4: width of each per-requester burst-length field.
REQ-003 The module SHALL have parameter TO_CYC, default 16: consecutive res_ready-low cycles in GRANT that trigger a timeout.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NUM_REQ  level request per requester; bit i belongs to requester i.
REQ-007 len  input  NUM_REQ*LEN_W  burst length per requester; field i is len[i*LEN_W +: LEN_W]; burst = field+1 beats.
REQ-008 res_ready  input  1  shared resource accepts one beat this cycle.
REQ-009 grant  output  NUM_REQ  registered one-hot grant; all-zero when no owner.
REQ-010 gnt_id  output  3  registered binary index of current owner; 0 when idle.
REQ-011 busy  output  1  registered; high while state is GRANT.
REQ-012 beat_en  output  1  combinational; busy & res_ready & req[gnt_id].
REQ-013 last_beat  output  1  combinational; beat_en while beat counter equals 0.
REQ-014 timeout_err  output  1  registered one-cycle pulse on timeout abort.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-016 In IDLE with req nonzero, the block SHALL select the winner round-robin: search starts at index ptr+1 (mod NUM_REQ), first set req bit wins.
REQ-017 Grant latency SHALL be one cycle: req sampled in IDLE -> grant/gnt_id/busy asserted on the next edge, state GRANT.
REQ-018 On entering GRANT, the beat counter SHALL load the winner's len field, captured in the IDLE cycle; later len changes SHALL be ignored.
REQ-019 ptr SHALL be updated to the winner index on every IDLE->GRANT transition.
REQ-020 In GRANT, each beat_en cycle SHALL decrement the beat counter; with res_ready low the counter SHALL hold.
REQ-021 On last_beat the block SHALL return to IDLE at the next edge, clearing grant, gnt_id and busy.
REQ-022 At least one IDLE cycle SHALL separate consecutive grants; back-to-back grants are not permitted.
REQ-023 If the owner deasserts req during GRANT, the block SHALL abort to IDLE at the next edge without timeout_err; beat_en SHALL be low in that cycle.
REQ-024 A stall counter SHALL count consecutive GRANT cycles with res_ready low and clear on any res_ready-high cycle or on leaving GRANT.
REQ-025 When the stall counter reaches TO_CYC, the block SHALL go to IDLE at the next edge and pulse timeout_err for exactly that one cycle.
REQ-026 Owner req drop and timeout in the same cycle SHALL be treated as a req-drop abort (no timeout_err).
REQ-027 Requests from non-owners during GRANT SHALL have no effect until IDLE.
REQ-028 grant SHALL never have more than one bit set; no requester i >= NUM_REQ SHALL ever be granted.
REQ-029 len field 0 SHALL produce a single-beat burst; all-ones SHALL produce 2^LEN_W beats.

Reset
REQ-030 While rst is high: state IDLE, grant 0, gnt_id 0, busy 0, timeout_err 0, beat counter 0, stall counter 0, ptr NUM_REQ-1 (requester 0 highest priority first).
REQ-031 Reset asserted mid-burst SHALL drop grant immediately (asynchronously) with no timeout_err; the first arbitration after release SHALL again start at requester 0.

Verification
REQ-032 After reset, req=6'b100001, all len=0, res_ready=1 -> grant=000001 for 1 cycle, IDLE 1 cycle, then grant=100000 for 1 cycle.
REQ-033 req=6'b111111 held, len=0, res_ready=1 -> grants rotate 0,1,2,3,4,5,0 with one idle cycle between each.
REQ-034 Owner 2, len[2]=3, res_ready toggling 1,0,1,0,... -> exactly 4 beat_en pulses, last_beat on the 4th, busy for 8 cycles.
REQ-035 Owner 1, len[1]=5, res_ready held 0 -> timeout_err pulse after 16 stalled GRANT cycles, grant cleared, next arbitration starts at requester 2.
REQ-036 Owner 4 drops req after 2 of 8 beats -> return to IDLE next edge, timeout_err stays 0, ptr=4.
REQ-037 rst pulsed mid-burst on owner 3 -> grant 0 immediately; after release with req=6'b001001, requester 0 wins.
